// File: rtl/aes_pkg.sv
// aes_pkg: shared AES primitives and encodings for the iterative encryptor
// Provides the FSM state encoding (IDLE/ROUND/DONE), the key-step phase encoding,
// the rcon start value, and the GF(2^8), S-box, word and column transforms
// used by aes_encrypt_iter and aes_key_step.
package aes_pkg;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ROUND   = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] PH_HOLD   = 2'd0;
    localparam logic [1:0] PH_ROT    = 2'd1;
    localparam logic [1:0] PH_SUB    = 2'd2;
    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, x;
        r = 8'h01;
        x = a;
        for (int i = 0; i < 7; i++) begin
            x = gmul(x, x);
            r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte n sits at [127-8n -: 8]; row = n%4, column = n/4
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        return o;
    endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: combinational one-step advance of the AES key-schedule window
// Ports: win (current key window, word 0 in the top bits), rcon, phase (HOLD/ROT/SUB);
// win_next (window after the step), rk (128-bit round key for the current round).
module aes_key_step import aes_pkg::*; #(
    parameter int KEY_BITS = 128
) (
    input  logic [KEY_BITS-1:0] win,
    input  logic [7:0]          rcon,
    input  logic [1:0]          phase,
    output logic [KEY_BITS-1:0] win_next,
    output logic [127:0]        rk
);
    logic [31:0]  t, n0, n1, n2, n3;
    logic [127:0] nk;

    always_comb begin
        t  = phase == PH_ROT ? sub_word(rot_word(win[31:0])) ^ {rcon, 24'h0} : sub_word(win[31:0]);
        n0 = win[KEY_BITS-1 -: 32] ^ t;
        n1 = win[KEY_BITS-33 -: 32] ^ n0;
        n2 = win[KEY_BITS-65 -: 32] ^ n1;
        n3 = win[KEY_BITS-97 -: 32] ^ n2;
        nk = {n0, n1, n2, n3};
        // HOLD only occurs for AES-256 round 1, whose key is the second half of the cipher key
        rk = phase == PH_HOLD ? win[127:0] : nk;
    end

    generate
        if (KEY_BITS == 128) begin : g_128
            assign win_next = nk;
        end else begin : g_256
            assign win_next = phase == PH_HOLD ? win : {win[KEY_BITS-129:0], nk};
        end
    endgenerate
endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/256 encryptor, one round per clock, valid/ready on both sides
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_block/in_key accept a block;
// out_valid/out_ready/out_block deliver ciphertext (held until taken); busy is high in ROUND.
module aes_encrypt_iter import aes_pkg::*; #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_block,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block,
    output logic                busy
);
    localparam logic [3:0] NR = KEY_BITS == 256 ? 4'd14 : 4'd10;

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_encrypt_iter: KEY_BITS must be 128 or 256");
        end
    endgenerate

    logic [1:0]          fsm_q, fsm_d;
    logic [127:0]        st_q, st_d, out_q, out_d;
    logic [KEY_BITS-1:0] win_q, win_d, win_next;
    logic [7:0]          rcon_q, rcon_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [1:0]          phase;
    logic [127:0]        rk, shifted, round_out;

    // AES-256: round 1 uses the stored second key half, then steps alternate rot (even) / sub (odd)
    assign phase = KEY_BITS == 128 ? PH_ROT : rnd_q == 4'd1 ? PH_HOLD : rnd_q[0] ? PH_SUB : PH_ROT;

    aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
        .win      (win_q),
        .rcon     (rcon_q),
        .phase    (phase),
        .win_next (win_next),
        .rk       (rk)
    );

    always_comb begin
        shifted   = shift_rows(sub_bytes(st_q));
        round_out = (rnd_q == NR ? shifted : mix_columns(shifted)) ^ rk;
        fsm_d     = fsm_q;
        st_d      = st_q;
        out_d     = out_q;
        win_d     = win_q;
        rcon_d    = rcon_q;
        rnd_d     = rnd_q;
        if (fsm_q == S_IDLE && in_valid) begin
            st_d   = in_block ^ in_key[KEY_BITS-1 -: 128];
            win_d  = in_key;
            rcon_d = RCON_INIT;
            rnd_d  = 4'd1;
            fsm_d  = S_ROUND;
        end else if (fsm_q == S_ROUND) begin
            st_d   = round_out;
            win_d  = win_next;
            rcon_d = phase == PH_ROT ? xtime(rcon_q) : rcon_q;
            rnd_d  = rnd_q + 4'd1;
            out_d  = rnd_q == NR ? round_out : out_q;
            fsm_d  = rnd_q == NR ? S_DONE : S_ROUND;
        end else if (fsm_q == S_DONE && out_ready) begin
            fsm_d  = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= S_IDLE;
            st_q   <= '0;
            out_q  <= '0;
            win_q  <= '0;
            rcon_q <= RCON_INIT;
            rnd_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            out_q  <= out_d;
            win_q  <= win_d;
            rcon_q <= rcon_d;
            rnd_q  <= rnd_d;
        end
    end

    assign in_ready  = fsm_q == S_IDLE;
    assign out_valid = fsm_q == S_DONE;
    assign busy      = fsm_q == S_ROUND;
    assign out_block = out_q;
endmodule
